icache_fill_fsm: RTL and testbench

ICACHE_FILL_FSM -- requirements
Module: icache_fill_fsm

---
 rtl/cache_pkg.sv | 22 ++
 rtl/dff.sv | 21 ++
 rtl/icache_fill_fsm_fill_counter.sv | 24 ++
 rtl/icache_fill_fsm.sv | 101 ++++++++++
 tb/tb_icache_fill_fsm.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction- and data-cache block fill controllers.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_OFF_W  = $clog2(BLOCK_WORDS);
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } fill_state_e;

    // Byte address of the first word of the block holding addr (power-of-two blocks of 16-bit words).
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr,
                                                     input int                words);
        return addr & ~ADDR_W'((2 * words) - 1);
    endfunction

endpackage

// File: rtl/dff.sv
// Library flop cell: parameterised width, asynchronous active-low reset to RESET_VAL.
module dff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples its pre-edge inputs, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/icache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and enable; tracks issued and received words of a fill.
module fill_counter
    import cache_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: streams one block from pipelined memory into the data array,
// then writes the tag and pulses fill_done.
module icache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    output logic                  fsm_busy,
    output logic                  memory_read,
    output logic [ADDR_W-1:0]     memory_address,
    input  logic                  memory_valid,
    input  logic [DATA_W-1:0]     memory_data,
    output logic                  write_data_array,
    output logic [WORD_OFF_W-1:0] fill_word,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  write_tag_array,
    output logic                  fill_done
);

    localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    // Counters and fill_word are sized for at most eight words; latency must be causal.
    if (BLOCK_WORDS < 2 || BLOCK_WORDS > 8 || MEM_LATENCY < 1) begin : g_param_check
        $error("icache_fill_fsm: unsupported BLOCK_WORDS or MEM_LATENCY");
    end

    fill_state_e       state;
    fill_state_e       state_next;
    logic [1:0]        state_q;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue;
    logic [CNT_W-1:0]  recv;
    logic              in_idle;
    logic              accept;

    dff #(
        .WIDTH    (2),
        .RESET_VAL(ST_IDLE)
    ) u_state_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (state_next),
        .q    (state_q)
    );

    assign state   = fill_state_e'(state_q);
    assign in_idle = (state == ST_IDLE);
    assign accept  = (state == ST_FILL) && memory_valid;

    // Both counters sit at zero in IDLE so a fill always starts from word 0.
    fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (memory_read),
        .clr  (in_idle),
        .count(issue)
    );

    fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .clr  (in_idle),
        .count(recv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
        end else if (in_idle && miss_detected) begin
            base <= block_base(miss_address, BLOCK_WORDS);
        end
    end

    // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (miss_detected)               state_next = ST_FILL;
            ST_FILL: if (accept && recv == LAST_WORD) state_next = ST_DONE;
            ST_DONE:                                  state_next = ST_IDLE;
            default:                                  state_next = ST_IDLE;
        endcase
    end

    assign fsm_busy         = !in_idle;
    assign memory_read      = (state == ST_FILL) && (issue < NUM_WORDS);
    assign memory_address   = memory_read ? base + ADDR_W'({issue, 1'b0}) : '0;
    assign write_data_array = accept;
    assign fill_word        = accept ? recv[WORD_OFF_W-1:0] : '0;
    assign fill_data        = accept ? memory_data : '0;
    assign write_tag_array  = (state == ST_DONE);
    assign fill_done        = (state == ST_DONE);

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Directed bench for icache_fill_fsm with a small pipelined-memory responder driven from the stimulus thread.
module tb_icache_fill_fsm;

    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        memory_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic        fill_done;

    typedef struct {
        int          ready;
        logic [15:0] addr;
    } req_t;

    req_t pend[$];
    int   cyc       = 0;
    bit   gap_mode  = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    icache_fill_fsm #(
        .BLOCK_WORDS(8),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .fsm_busy        (fsm_busy),
        .memory_read     (memory_read),
        .memory_address  (memory_address),
        .memory_valid    (memory_valid),
        .memory_data     (memory_data),
        .write_data_array(write_data_array),
        .fill_word       (fill_word),
        .fill_data       (fill_data),
        .write_tag_array (write_tag_array),
        .fill_done       (fill_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the memory model returns each request MEM_LATENCY cycles later, in order.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        memory_valid = 1'b0;
        memory_data  = '0;
        if (pend.size() > 0 && pend[0].ready <= cyc && (!gap_mode || (cyc % 2 == 0))) begin
            memory_valid = 1'b1;
            memory_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        if (memory_read === 1'b1) pend.push_back('{cyc + MEM_LATENCY, memory_address});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},  32'(fsm_busy),         32'd0);
        check({tag, " read"},  32'(memory_read),      32'd0);
        check({tag, " addr"},  32'(memory_address),   32'd0);
        check({tag, " wr"},    32'(write_data_array), 32'd0);
        check({tag, " word"},  32'(fill_word),        32'd0);
        check({tag, " data"},  32'(fill_data),        32'd0);
        check({tag, " tag"},   32'(write_tag_array),  32'd0);
        check({tag, " done"},  32'(fill_done),        32'd0);
    endtask

    // Cycle c of a fill whose miss was sampled at the end of cycle 0 (latency 4 timeline).
    task automatic run_fill(input string name, input logic [15:0] base, input bit hold,
                            input logic [15:0] alt_addr, input int last_c);
        for (int c = 1; c <= last_c; c++) begin
            bit r;
            bit w;
            tick();
            if (c == 1 && !hold) miss_detected = 1'b0;
            if (c == 3) miss_address = alt_addr;
            #1;
            r = (c <= 8);
            w = (c >= 5 && c <= 12);
            check($sformatf("%s c%0d busy", name, c), 32'(fsm_busy), 32'(c <= 13));
            check($sformatf("%s c%0d read", name, c), 32'(memory_read), 32'(r));
            check($sformatf("%s c%0d addr", name, c), 32'(memory_address),
                  32'(r ? base + 16'(2 * (c - 1)) : 16'h0000));
            check($sformatf("%s c%0d wr", name, c), 32'(write_data_array), 32'(w));
            check($sformatf("%s c%0d word", name, c), 32'(fill_word), w ? 32'(c - 5) : 32'd0);
            check($sformatf("%s c%0d data", name, c), 32'(fill_data),
                  32'(w ? mem_word(base + 16'(2 * (c - 5))) : 16'h0000));
            check($sformatf("%s c%0d tag", name, c), 32'(write_tag_array), 32'(c == 13));
            check($sformatf("%s c%0d done", name, c), 32'(fill_done), 32'(c == 13));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        bit got_done;

        // Reset with miss and stray memory data present: everything stays quiet.
        rst_n         = 1'b0;
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        memory_valid  = 1'b1;
        memory_data   = 16'hFFFF;
        #22;
        check_all_zero("reset");
        miss_detected = 1'b0;
        memory_valid  = 1'b0;
        memory_data   = '0;
        rst_n         = 1'b1;

        // Returned data while idle is ignored.
        tick();
        memory_valid = 1'b1;
        memory_data  = 16'hBEEF;
        #1;
        check("idle valid wr", 32'(write_data_array), 32'd0);
        check("idle valid busy", 32'(fsm_busy), 32'd0);

        // Basic fill at 0x1236, with a mid-fill miss_address change.
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        run_fill("f1236", 16'h1230, 1'b0, 16'h7770, 14);

        // Top-of-memory block: last request 0xFFFE, no wrap.
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'hFFF8;
        run_fill("fFFF8", 16'hFFF0, 1'b0, 16'hFFF8, 14);

        // memory_valid only on even cycles: all 8 words land in order, busy held.
        tick();
        gap_mode      = 1'b1;
        miss_detected = 1'b1;
        miss_address  = 16'h4444;
        nw            = 0;
        got_done      = 1'b0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            tick();
            if (c == 1) miss_detected = 1'b0;
            #1;
            check($sformatf("gap c%0d busy", c), 32'(fsm_busy), 32'd1);
            if (write_data_array === 1'b1) begin
                check($sformatf("gap w%0d word", nw), 32'(fill_word), 32'(nw % 8));
                check($sformatf("gap w%0d data", nw), 32'(fill_data),
                      32'(mem_word(16'h4440 + 16'(2 * nw))));
                nw++;
            end
            if (fill_done === 1'b1) begin
                check("gap words before done", 32'(nw), 32'd8);
                got_done = 1'b1;
            end
        end
        check("gap done seen", 32'(got_done), 32'd1);
        gap_mode = 1'b0;
        tick();
        #1;
        check("gap idle after done", 32'(fsm_busy), 32'd0);

        // Reset in cycle 6 of a fill; late data must not write; then a clean fill at 0x0040.
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        run_fill("pre_rst", 16'h1230, 1'b0, 16'h1236, 5);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-fill reset");
        tick();
        #1;
        check("in reset late valid wr", 32'(write_data_array), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check($sformatf("post rst %0d wr", i), 32'(write_data_array), 32'd0);
            check($sformatf("post rst %0d busy", i), 32'(fsm_busy), 32'd0);
            check($sformatf("post rst %0d read", i), 32'(memory_read), 32'd0);
        end
        pend.delete();
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h0040;
        run_fill("f0040", 16'h0040, 1'b0, 16'h0040, 14);

        // Miss held across two blocks: the second fill starts right after the IDLE cycle.
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h2004;
        run_fill("hold1", 16'h2000, 1'b1, 16'h3008, 14);
        run_fill("hold2", 16'h3000, 1'b0, 16'h3008, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
